// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg: state encoding, opcodes and datapath-select codes for the multicycle controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BEQ      = 4'd9;
  localparam state_t S_JAL      = 4'd10;
  localparam state_t S_LUI      = 4'd11;
  localparam state_t S_TRAP     = 4'd12;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src_of = IMM_S;
      OP_BEQ:  imm_src_of = IMM_B;
      OP_JAL:  imm_src_of = IMM_J;
      OP_LUI:  imm_src_of = IMM_U;
      default: imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_alu_decoder.sv
// ============================================================================
// mc_alu_decoder: maps funct3/funct7b5 to an ALU operation for EXECR/EXECI.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic       op_b5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct3)
      // op[5] separates R-type from I-type, so addi can never become sub
      3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller: FSM sequencing a multi-cycle RV32I-subset datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [2:0]       imm_src,
  output logic             instr_done,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  state_t     next_state;
  logic [2:0] dec_alu;
  logic       dec_illegal;

  mc_alu_decoder u_alu_decoder (
    .op_b5       (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (dec_alu),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= next_state;
      if (instr_done) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          OP_LUI:       next_state = S_LUI;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
      S_EXECR,
      S_EXECI:    next_state = dec_illegal ? S_TRAP : S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_LUI:      next_state = S_FETCH;
      default:    next_state = S_TRAP;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_control = ALU_ADD;
    imm_src     = imm_src_of(op);
    instr_done  = 1'b0;
    trap        = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_RS1;
        alu_control = dec_alu;
      end
      S_EXECI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = SRCA_RS1;
        alu_control = ALU_SUB;
        pc_write    = zero;
        instr_done  = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: trap = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller: randomized and directed checks against an instruction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  alu_control, imm_src;
  logic        instr_done, trap;
  logic [31:0] instret;
  logic [3:0]  state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_ret = 0;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .instr_done(instr_done), .trap(trap), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  // Instruction-level model: cost, writes and ALU operation per opcode
  function automatic int exp_cycles(input logic [6:0] o, input int fw, input int mw);
    int base;
    case (o)
      7'b0000011: base = 5;
      7'b0100011: base = 4;
      7'b1100011: base = 3;
      7'b0110111: base = 3;
      default:    base = 4;
    endcase
    return base + fw + ((o == 7'b0000011 || o == 7'b0100011) ? mw : 0);
  endfunction

  function automatic int exp_regw(input logic [6:0] o);
    return (o == 7'b0100011 || o == 7'b1100011) ? 0 : 1;
  endfunction

  function automatic int exp_pcw(input logic [6:0] o, input logic z);
    return 1 + ((o == 7'b1101111) ? 1 : 0) + ((o == 7'b1100011 && z) ? 1 : 0);
  endfunction

  function automatic int exp_memw(input logic [6:0] o, input int mw);
    return (o == 7'b0100011) ? mw + 1 : 0;
  endfunction

  function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (o == 7'b1100011) return 3'b001;
    if (o != 7'b0110011 && o != 7'b0010011) return 3'b000;
    case (f3)
      3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // Drives one instruction with fw fetch wait cycles and mw data wait cycles
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw,
                           output int cyc, output int irw, output int regw,
                           output int pcw, output int memw, output logic [2:0] alu_seen,
                           output logic done_ok, output logic trapped);
    int fc = 0;
    int mc = 0;
    logic after_dec = 1'b0;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    cyc = 0; irw = 0; regw = 0; pcw = 0; memw = 0;
    alu_seen = 3'bxxx; done_ok = 1'b0; trapped = 1'b0;
    while (cyc < 60 && !done_ok && !trapped) begin
      @(negedge clk);
      if (mem_req && !adr_src) begin mem_ready = (fc >= fw); fc++; end
      else if (mem_req)        begin mem_ready = (mc >= mw); mc++; end
      else                     mem_ready = 1'b0;
      #1;
      cyc++;
      irw  += int'(ir_write);
      regw += int'(reg_write);
      pcw  += int'(pc_write);
      memw += int'(mem_write);
      if (after_dec) begin alu_seen = alu_control; after_dec = 1'b0; end
      if (state == 4'd1) after_dec = 1'b1;
      if (instr_done) done_ok = 1'b1;
      if (trap) trapped = 1'b1;
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_ret = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; op = 7'b0110011; funct3 = 3'b000;
    funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++; if (state !== 4'd0 || instret !== 32'd0) begin bad++;
      $display("FAIL reset_state: got state=%0d instret=%0d expected 0/0", state, instret); end
    total++; if ({mem_req, adr_src, alu_src_a, alu_src_b, alu_control, result_src} !== 11'b1_0_00_10_000_10) begin bad++;
      $display("FAIL reset_fetch_outs: got %b expected %b",
               {mem_req, adr_src, alu_src_a, alu_src_b, alu_control, result_src}, 11'b1_0_00_10_000_10); end
    total++; if ({ir_write, pc_write, reg_write, mem_write, instr_done, trap} !== 6'b0) begin bad++;
      $display("FAIL reset_enables: got %b expected 000000",
               {ir_write, pc_write, reg_write, mem_write, instr_done, trap}); end
    mem_ready = 1'b1; #1;
    total++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin bad++;
      $display("FAIL fetch_ready_enables: got ir=%b pc=%b expected 1/1", ir_write, pc_write); end
    mem_ready = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mix();
    logic [6:0] ops [7] = '{7'b0110011, 7'b0110011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b1101111, 7'b0110111};
    logic       f7s [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int cyc, irw, regw, pcw, memw; logic [2:0] alu; logic dn, tr;
    for (int i = 0; i < 7; i++) begin
      run_instr(ops[i], 3'b000, f7s[i], 1'b0, 0, 0, cyc, irw, regw, pcw, memw, alu, dn, tr);
      total++; if (cyc !== exp_cycles(ops[i], 0, 0)) begin bad++;
        $display("FAIL mix_cycles[%0d]: got %0d expected %0d", i, cyc, exp_cycles(ops[i], 0, 0)); end
      total++; if (alu !== exp_alu(ops[i], 3'b000, f7s[i])) begin bad++;
        $display("FAIL mix_alu[%0d]: got %b expected %b", i, alu, exp_alu(ops[i], 3'b000, f7s[i])); end
      if (dn) exp_ret++;
    end
    total++; if (instret !== exp_ret) begin bad++;
      $display("FAIL mix_instret: got %0d expected %0d", instret, exp_ret); end
  endtask

  task automatic test_addi();
    int cyc, irw, regw, pcw, memw; logic [2:0] alu; logic dn, tr;
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, cyc, irw, regw, pcw, memw, alu, dn, tr);
    if (dn) exp_ret++;
    total++; if (alu !== 3'b000 || cyc !== 4 || regw !== 1) begin bad++;
      $display("FAIL addi_not_sub: got alu=%b cyc=%0d regw=%0d expected 000/4/1", alu, cyc, regw); end
  endtask

  task automatic test_waits();
    int cyc, irw, regw, pcw, memw; logic [2:0] alu; logic dn, tr;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3, 2, cyc, irw, regw, pcw, memw, alu, dn, tr);
    if (dn) exp_ret++;
    total++; if (cyc !== 10) begin bad++;
      $display("FAIL lw_wait_cycles: got %0d expected 10", cyc); end
    total++; if (irw !== 1) begin bad++;
      $display("FAIL lw_wait_irwrite: got %0d expected 1", irw); end
    total++; if (instret !== exp_ret) begin bad++;
      $display("FAIL lw_wait_instret: got %0d expected %0d", instret, exp_ret); end
  endtask

  task automatic test_beq();
    int cyc, irw, regw, pcw, memw; logic [2:0] alu; logic dn, tr;
    for (int z = 0; z < 2; z++) begin
      run_instr(7'b1100011, 3'b000, 1'b0, 1'(z), 0, 0, cyc, irw, regw, pcw, memw, alu, dn, tr);
      if (dn) exp_ret++;
      total++; if (pcw !== exp_pcw(7'b1100011, 1'(z)) || cyc !== 3) begin bad++;
        $display("FAIL beq_zero%0d: got pcw=%0d cyc=%0d expected %0d/3", z, pcw, cyc,
                 exp_pcw(7'b1100011, 1'(z))); end
    end
  endtask

  task automatic test_random();
    logic [6:0] kinds [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                              7'b1100011, 7'b1101111, 7'b0110111};
    logic [2:0] f3s [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    int cyc, irw, regw, pcw, memw, fw, mw; logic [2:0] alu, f3; logic dn, tr, f7, z;
    logic [6:0] o;
    for (int i = 0; i < 30; i++) begin
      o  = kinds[$urandom_range(6, 0)];
      f3 = f3s[$urandom_range(3, 0)];
      f7 = 1'($urandom_range(1, 0));
      z  = 1'($urandom_range(1, 0));
      fw = $urandom_range(3, 0);
      mw = $urandom_range(3, 0);
      run_instr(o, f3, f7, z, fw, mw, cyc, irw, regw, pcw, memw, alu, dn, tr);
      if (dn) exp_ret++;
      total++; if (!dn || tr || cyc !== exp_cycles(o, fw, mw)) begin bad++;
        $display("FAIL rnd_cycles[%0d] op=%b: got %0d done=%b expected %0d", i, o, cyc, dn,
                 exp_cycles(o, fw, mw)); end
      total++; if (irw !== 1 || regw !== exp_regw(o) || pcw !== exp_pcw(o, z) || memw !== exp_memw(o, mw)) begin bad++;
        $display("FAIL rnd_enables[%0d] op=%b: got ir=%0d reg=%0d pc=%0d mw=%0d expected 1/%0d/%0d/%0d",
                 i, o, irw, regw, pcw, memw, exp_regw(o), exp_pcw(o, z), exp_memw(o, mw)); end
      total++; if (alu !== exp_alu(o, f3, f7)) begin bad++;
        $display("FAIL rnd_alu[%0d] op=%b f3=%b: got %b expected %b", i, o, f3, alu, exp_alu(o, f3, f7)); end
    end
    total++; if (instret !== exp_ret) begin bad++;
      $display("FAIL rnd_instret: got %0d expected %0d", instret, exp_ret); end
  endtask

  task automatic test_reset_midread();
    logic found = 1'b0;
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      mem_ready = mem_req && !adr_src;
      #1;
      if (state == 4'd3) found = 1'b1;
    end
    total++; if (!found) begin bad++;
      $display("FAIL midread_reach: got state=%0d expected 3", state); end
    rst_n = 1'b0; #1;
    total++; if (state !== 4'd0 || instret !== 32'd0) begin bad++;
      $display("FAIL midread_async: got state=%0d instret=%0d expected 0/0", state, instret); end
    @(posedge clk); #1;
    total++; if (state !== 4'd0 || instret !== 32'd0 || mem_req !== 1'b1 || reg_write !== 1'b0) begin bad++;
      $display("FAIL midread_edge: got state=%0d instret=%0d req=%b rw=%b expected 0/0/1/0",
               state, instret, mem_req, reg_write); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_ret = 0;
  endtask

  task automatic test_illegal_funct3();
    int cyc, irw, regw, pcw, memw; logic [2:0] alu; logic dn, tr;
    run_instr(7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0, cyc, irw, regw, pcw, memw, alu, dn, tr);
    total++; if (!tr || dn || cyc !== 4 || regw !== 0 || instret !== exp_ret) begin bad++;
      $display("FAIL illegal_funct3: got trap=%b done=%b cyc=%0d regw=%0d instret=%0d expected 1/0/4/0/%0d",
               tr, dn, cyc, regw, instret, exp_ret); end
    apply_reset();
  endtask

  task automatic test_trap();
    int cyc, irw, regw, pcw, memw, errs; logic [2:0] alu; logic dn, tr;
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0, cyc, irw, regw, pcw, memw, alu, dn, tr);
    if (dn) exp_ret++;
    run_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0, cyc, irw, regw, pcw, memw, alu, dn, tr);
    total++; if (!tr || dn || cyc !== 3) begin bad++;
      $display("FAIL trap_entry: got trap=%b done=%b cyc=%0d expected 1/0/3", tr, dn, cyc); end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      if ({mem_req, ir_write, pc_write, reg_write, mem_write, instr_done, trap} !== 7'b0000001
          || state !== 4'd12) errs++;
    end
    mem_ready = 1'b0;
    total++; if (errs !== 0) begin bad++;
      $display("FAIL trap_hold: got %0d bad cycles expected 0", errs); end
    total++; if (instret !== exp_ret) begin bad++;
      $display("FAIL trap_instret: got %0d expected %0d", instret, exp_ret); end
  endtask

  initial begin
    test_reset();
    test_mix();
    test_addi();
    test_waits();
    test_beq();
    test_random();
    test_reset_midread();
    test_illegal_funct3();
    test_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
